// File: rtl/retrans_timer_engine.sv
// Retransmission timer engine: per-QP deadline table with a round-robin expiry scanner.
// Optional macro TIMER_EVENT_CNT_EN adds the saturating ov_timeout_cnt event counter output.
module retrans_timer_engine #(
    parameter int QP_NUM        = 64,
    parameter int TICK_CYCLES   = 1024,
    parameter int TIMEOUT_TICKS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_timer_set_empty,
    input  logic [25:0] iv_timer_set_dout,
    output logic        o_timer_set_rd_en,
    input  logic        i_time_out_prog_full,
    output logic        o_time_out_wr_en,
`ifdef TIMER_EVENT_CNT_EN
    output logic [31:0] ov_timeout_cnt,
`endif
    output logic [23:0] ov_time_out_din
);

    localparam int IDX_W = $clog2(QP_NUM);
    localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(QP_NUM - 1);
    localparam logic [15:0]      TIMEOUT_DL = 16'(TIMEOUT_TICKS);
    localparam logic [1:0]       ACT_SET    = 2'b01;
    localparam logic [1:0]       ACT_STOP   = 2'b10;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] init_idx;
    logic [IDX_W-1:0] scan_idx;
    logic [PRE_W-1:0] pre_cnt;
    logic [15:0]      tick_now;

    logic             tbl_vld [QP_NUM];
    logic [23:0]      tbl_qpn [QP_NUM];
    logic [15:0]      tbl_dl  [QP_NUM];

    logic [1:0]       cmd_act;
    logic [23:0]      cmd_qpn;
    logic [IDX_W-1:0] cmd_idx;
    logic [15:0]      scan_age;
    logic             scan_expired;
    logic             collide;
    logic             fire_p0;
    logic             evt_vld_p1;
    logic [23:0]      evt_qpn_p1;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && init_idx == IDX_LAST) state_d = ST_RUN;
    end

    assign o_timer_set_rd_en = !rst && (state_q == ST_RUN) && !i_timer_set_empty;

    assign cmd_act = iv_timer_set_dout[25:24];
    assign cmd_qpn = iv_timer_set_dout[23:0];
    assign cmd_idx = iv_timer_set_dout[IDX_W-1:0];

    // Tick time base runs in both states so deadlines stay meaningful across INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt  <= '0;
            tick_now <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt  <= '0;
            tick_now <= tick_now + 16'd1;
        end else begin
            pre_cnt  <= pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_idx <= '0;
            scan_idx <= '0;
        end else if (state_q == ST_INIT) begin
            init_idx <= init_idx + 1'b1;
        end else begin
            scan_idx <= scan_idx + 1'b1;
        end
    end

    // Expiry uses a signed-distance test so the 16-bit deadline may wrap.
    assign scan_age     = tick_now - tbl_dl[scan_idx];
    assign scan_expired = tbl_vld[scan_idx] && !scan_age[15];
    assign collide      = o_timer_set_rd_en && (cmd_idx == scan_idx);
    assign fire_p0      = !rst && (state_q == ST_RUN) && scan_expired
                          && !i_time_out_prog_full && !collide;

    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            tbl_vld[init_idx] <= 1'b0;
            tbl_qpn[init_idx] <= '0;
            tbl_dl[init_idx]  <= '0;
        end else begin
            if (fire_p0) tbl_vld[scan_idx] <= 1'b0;
            if (o_timer_set_rd_en && cmd_act == ACT_SET) begin
                tbl_vld[cmd_idx] <= 1'b1;
                tbl_qpn[cmd_idx] <= cmd_qpn;
                tbl_dl[cmd_idx]  <= tick_now + TIMEOUT_DL;
            end else if (o_timer_set_rd_en && cmd_act == ACT_STOP
                         && tbl_vld[cmd_idx] && tbl_qpn[cmd_idx] == cmd_qpn) begin
                tbl_vld[cmd_idx] <= 1'b0;
            end
        end
    end

    // Stage p0 -> p1: expiry decision registered into the event FIFO push.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_vld_p1 <= 1'b0;
            evt_qpn_p1 <= '0;
        end else begin
            evt_vld_p1 <= fire_p0;
            if (fire_p0) evt_qpn_p1 <= tbl_qpn[scan_idx];
        end
    end

    assign o_time_out_wr_en = evt_vld_p1;
    assign ov_time_out_din  = evt_qpn_p1;

`ifdef TIMER_EVENT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)                                    ov_timeout_cnt <= '0;
        else if (evt_vld_p1 && ov_timeout_cnt != '1) ov_timeout_cnt <= ov_timeout_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_retrans_timer_engine.sv
// Scoreboard bench for retrans_timer_engine: expected expiry events are queued at SET time
// and matched (QPN and arrival window) when the DUT pushes an event.
module tb_retrans_timer_engine;

    localparam int QP_NUM  = 64;
    localparam int TC      = 4;
    localparam int TO      = 32;

    typedef struct {
        logic [23:0] qpn;
        int          lo;
        int          hi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        set_empty;
    logic [25:0] set_dout;
    logic        set_rd_en;
    logic        prog_full;
    logic        evt_wr_en;
    logic [23:0] evt_din;
`ifdef TIMER_EVENT_CNT_EN
    logic [31:0] evt_cnt_dut;
`endif

    exp_t exp_q[$];
    int   cyc        = 0;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   unexp_cnt  = 0;
    int   evt_seen   = 0;

    retrans_timer_engine #(
        .QP_NUM(QP_NUM),
        .TICK_CYCLES(TC),
        .TIMEOUT_TICKS(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_timer_set_empty(set_empty),
        .iv_timer_set_dout(set_dout),
        .o_timer_set_rd_en(set_rd_en),
        .i_time_out_prog_full(prog_full),
        .o_time_out_wr_en(evt_wr_en),
`ifdef TIMER_EVENT_CNT_EN
        .ov_timeout_cnt(evt_cnt_dut),
`endif
        .ov_time_out_din(evt_din)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Event monitor: pops the scoreboard on every push from the DUT.
    always @(negedge clk) begin
        if (!rst && evt_wr_en) begin
            evt_seen++;
            if (exp_q.size() == 0) begin
                unexp_cnt++;
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("evt_qpn", {8'd0, evt_din}, {8'd0, e.qpn});
                check_eq("evt_window", {31'd0, (cyc >= e.lo) && (cyc <= e.hi)}, 32'd1);
            end
        end
    end

    task automatic send_cmd(input logic [1:0] act, input logic [23:0] qpn, output int set_cyc);
        int n;
        n = 0;
        @(negedge clk);
        set_empty = 1'b0;
        set_dout  = {act, qpn};
        #1;
        while (!set_rd_en && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check_eq("pop_timeout", {31'd0, set_rd_en}, 32'd1);
        set_cyc = cyc;
        @(posedge clk);
        #1;
        set_empty = 1'b1;
    endtask

    task automatic push_exp(input logic [23:0] qpn, input int set_cyc);
        exp_t e;
        e.qpn = qpn;
        e.lo  = set_cyc + (TO - 1) * TC;
        e.hi  = set_cyc + TO * TC + QP_NUM + 6;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq({"drain_", tag}, exp_q.size(), 32'd0);
        repeat (QP_NUM + 8) @(posedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int sc;
        int sc2;
        rst       = 1'b1;
        set_empty = 1'b0;
        set_dout  = {2'b00, 24'h0000AA};
        prog_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_wr_en", {31'd0, evt_wr_en}, 32'd0);
        check_eq("rst_din", {8'd0, evt_din}, 32'd0);
        check_eq("rst_rd_en", {31'd0, set_rd_en}, 32'd0);

        rst = 1'b0;
        #1;
        n = 0;
        while (!set_rd_en && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        check_eq("init_hold_cycles", n, 32'd64);
        @(posedge clk);
        #1;
        set_empty = 1'b1;

        // Basic SET -> single event
        send_cmd(2'b01, 24'h000005, sc);
        push_exp(24'h000005, sc);
        wait_drain("set5");

        // Index aliasing: second SET overwrites the first
        send_cmd(2'b01, 24'h000003, sc);
        send_cmd(2'b01, 24'h000043, sc2);
        push_exp(24'h000043, sc2);
        wait_drain("alias");

        // STOP cancels the timer
        send_cmd(2'b01, 24'h000007, sc);
        repeat (TC) @(posedge clk);
        send_cmd(2'b10, 24'h000007, sc);
        repeat (10 * TO * TC) @(posedge clk);

        // STOP with mismatching QPN on the same index is ignored
        send_cmd(2'b01, 24'h00000A, sc);
        send_cmd(2'b10, 24'h00004A, sc2);
        push_exp(24'h00000A, sc);
        wait_drain("stop_mismatch");

        // Reserved actions are consumed and discarded
        send_cmd(2'b11, 24'h00000B, sc);
        send_cmd(2'b00, 24'h00000C, sc);
        repeat (TO * TC + 2 * QP_NUM) @(posedge clk);

        // Back-pressure holds the expiry until released
        @(negedge clk);
        prog_full = 1'b1;
        send_cmd(2'b01, 24'h000009, sc);
        repeat (TO * TC + 200) @(posedge clk);
        @(negedge clk);
        begin
            exp_t e;
            e.qpn = 24'h000009;
            e.lo  = cyc;
            e.hi  = cyc + QP_NUM + 4;
            exp_q.push_back(e);
        end
        prog_full = 1'b0;
        wait_drain("backpressure");

        // Tick counter wrap: deadline lands past 0xFFFF
        @(negedge clk);
        force dut.tick_now = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.tick_now;
        send_cmd(2'b01, 24'h000021, sc);
        push_exp(24'h000021, sc);
        wait_drain("wrap");

        check_eq("unexpected_events", unexp_cnt, 32'd0);
        check_eq("event_total", evt_seen, 32'd5);
`ifdef TIMER_EVENT_CNT_EN
        check_eq("timeout_cnt", evt_cnt_dut, 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/retrans_timer_engine.md
RETRANS_TIMER_ENGINE -- requirements
Module: retrans_timer_engine

Interface
REQ-001 Parameter QP_NUM, default 64, timer table entries (power of two); entry index = qpn[log2(QP_NUM)-1:0].
REQ-002 Parameter TICK_CYCLES, default 1024, clk cycles per timer tick.
REQ-003 Parameter TIMEOUT_TICKS, default 256, ticks from SET to expiry; legal range 1..32767.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 i_timer_set_empty  input  1  command FIFO empty (FWFT).
REQ-007 iv_timer_set_dout  input  TIMER_CMD_WIDTH(26)  command {ACTION[25:24], QPN[23:0]}.
REQ-008 o_timer_set_rd_en  output  1  command pop.
REQ-009 i_time_out_prog_full  input  1  event FIFO programmable-full.
REQ-010 o_time_out_wr_en  output  1  event push.
REQ-011 ov_time_out_din  output  TIMER_EVENT_WIDTH(24)  expired QPN.

Function
REQ-012 States: INIT (clears one table entry per cycle, QP_NUM cycles, then RUN) and RUN; no other states.
REQ-013 Each entry: valid bit, 24-bit stored QPN, 16-bit deadline.
REQ-014 Prescaler counts 0..TICK_CYCLES-1; on wrap, 16-bit tick counter "now" increments modulo 2^16; both run in INIT and RUN.
REQ-015 o_timer_set_rd_en = RUN && !i_timer_set_empty, combinational; one command consumed per cycle.
REQ-016 ACTION 2'b01 SET: entry valid=1, QPN stored, deadline = now + TIMEOUT_TICKS (mod 2^16); SET on valid entry restarts it.
REQ-017 ACTION 2'b10 STOP: entry valid=0; STOP on invalid entry or stored-QPN mismatch is a no-op.
REQ-018 ACTION 2'b00 and 2'b11: popped and discarded, no table change.
REQ-019 Index aliasing: SET to an index holding a different QPN overwrites it silently.
REQ-020 Scanner index in RUN advances by one every cycle, wrapping QP_NUM-1 -> 0, regardless of back-pressure.
REQ-021 Scanned entry expired iff valid && (now - deadline) mod 2^16 < 2^15.
REQ-022 Expired and !i_time_out_prog_full: entry cleared; next cycle o_time_out_wr_en=1 for exactly one cycle, ov_time_out_din = stored QPN.
REQ-023 Expired and i_time_out_prog_full: no event, entry stays valid, retried on next scan pass.
REQ-024 Command and scanner on same index same cycle: command applied, no event that cycle.
REQ-025 Max detection latency after deadline: QP_NUM cycles + 1 (no back-pressure).
REQ-026 ov_time_out_din holds last value when o_time_out_wr_en=0.

Reset
REQ-027 rst asserted (any state, any cycle): next state INIT, scanner, prescaler, tick counter = 0, o_time_out_wr_en=0, ov_time_out_din=0, o_timer_set_rd_en=0.
REQ-028 Pending command not popped during reset or INIT; events in flight are dropped.

Configuration
REQ-029 Macro TIMER_EVENT_CNT_EN defined: adds output ov_timeout_cnt (32 bits), increments on each o_time_out_wr_en, saturates at 2^32-1, reset 0.
REQ-030 Macro undefined: port and counter absent; all other behaviour identical.

Verification
REQ-031 Reset, QP_NUM=64 -> rd_en=0 for 64 cycles, then first command popped on cycle 65.
REQ-032 TICK_CYCLES=4, TIMEOUT_TICKS=3, SET qpn 0x000005 -> single event 0x000005 within 12+65 cycles, none later.
REQ-033 SET qpn 0x07, STOP qpn 0x07 after 1 tick -> no event for 10*TIMEOUT_TICKS ticks.
REQ-034 SET qpn 0x09, hold prog_full=1 past deadline for 200 cycles -> no event; release -> event 0x09 within 65 cycles, exactly once.
REQ-035 Tick counter preset near 0xFFF0, SET with TIMEOUT_TICKS=32 -> expiry at wrapped deadline 0x0010, not immediately.
REQ-036 SET qpn 0x03 then SET qpn 0x43 (same index) -> only event 0x43; with TIMER_EVENT_CNT_EN ov_timeout_cnt=1.
